// File: rtl/mag_sched_pkg.sv
// Shared types and defaults for the magnitude-engine scheduler and its arbiter.
// Timeout option is compiled in with MAG_SCHED_TIMEOUT_EN.
package mag_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int N_REQ_DEF   = 4;
    localparam int N_DEF       = 16;
    localparam int YINT_W_DEF  = 2 * N_DEF + 1;
    localparam int SETTLE_DEF  = 4;
    localparam int STABLE_DEF  = 2;
    localparam int TMO_CYC_DEF = 1023;

    // RUN counter must hold both the settle window and the timeout limit.
    function automatic int cnt_width(input int settle, input int tmo);
        int m;
        m = (settle > tmo) ? settle : tmo;
        return $clog2(m + 1);
    endfunction

    function automatic int rr_wrap(input int v, input int n);
        return v % n;
    endfunction

endpackage

// File: rtl/mag_sched_rr_arbiter.sv
// Round-robin pick: first request at/after the pointer, wrapping; one-hot + index.
// Latency: combinational. Backpressure: none, pure function of req and pointer.
module mag_sched_rr_arbiter
    import mag_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IW    = $clog2(N_REQ_DEF)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);

    always_comb begin
        int   c;
        logic found;
        c     = 0;
        found = 1'b0;
        o_gnt = '0;
        o_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            c = rr_wrap(int'(i_ptr) + i, N_REQ);
            if (!found && i_req[c]) begin
                found    = 1'b1;
                o_gnt[c] = 1'b1;
                o_idx    = IW'(c);
            end
        end
        o_any = found;
    end

endmodule

// File: rtl/mag_sched.sv
// Shares one sqrt(a^2+b^2) engine among N_REQ requesters; MAG_SCHED_TIMEOUT_EN adds a RUN timeout.
// Latency: req->gnt 1 cycle from IDLE, gnt->done 2+SETTLE+convergence cycles.
// Backpressure: requests are only sampled in IDLE; losers simply hold req_i until granted.
module mag_sched
    import mag_sched_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int n       = N_DEF,
    parameter int SETTLE  = SETTLE_DEF,
    parameter int STABLE  = STABLE_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*n-1:0]       a_i,
    input  logic [N_REQ*n-1:0]       b_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [N_REQ-1:0]         done_o,
    output logic [2*n:0]             yint_o,
    output logic [n-1:0]             ydec_o,
    output logic [$clog2(N_REQ)-1:0] id_o,
    output logic                     busy_o,
    output logic                     err_o,
    output logic [n-1:0]             eng_a_o,
    output logic [n-1:0]             eng_b_o,
    output logic                     eng_rst_o,
    input  logic                     eng_fl_i,
    input  logic [2*n:0]             eng_yint_i,
    input  logic [n-1:0]             eng_ydec_i
);

    localparam int IW     = $clog2(N_REQ);
    localparam int YINT_W = 2 * n + 1;
    localparam int CNT_W  = cnt_width(SETTLE, TMO_CYC);
    localparam int STB_W  = $clog2(STABLE + 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [N_REQ-1:0]   w_arb_gnt;
    logic [IW-1:0]      w_arb_idx;
    logic               w_arb_any;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_id;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_done;
    logic [YINT_W-1:0]  r_yint;
    logic [n-1:0]       r_ydec;
    logic [n-1:0]       r_eng_a;
    logic [n-1:0]       r_eng_b;
    logic [CNT_W-1:0]   r_cnt;
    logic [STB_W-1:0]   r_stab;
    logic               w_settled;
    logic               w_conv;
    logic               w_tmo;
    logic               w_cnt_inc;
    logic               w_finish;

    mag_sched_rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .i_req (req_i),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    assign w_settled = (r_cnt >= CNT_W'(SETTLE));
    assign w_conv    = w_settled && eng_fl_i && (r_stab == STB_W'(STABLE - 1));

`ifdef MAG_SCHED_TIMEOUT_EN
    assign w_tmo     = (r_cnt == CNT_W'(TMO_CYC - 1)) && !w_conv;
    assign w_cnt_inc = 1'b1;
`else
    assign w_tmo     = 1'b0;
    // Without a timeout the counter only has to cover the settle window.
    assign w_cnt_inc = !w_settled;
`endif

    assign w_finish = w_conv || w_tmo;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_arb_any) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = RUN;
            RUN:     if (w_finish) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr   <= '0;
            r_id    <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_yint  <= '0;
            r_ydec  <= '0;
            r_eng_a <= '0;
            r_eng_b <= '0;
            r_cnt   <= '0;
            r_stab  <= '0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_arb_any) begin
                        r_gnt <= w_arb_gnt;
                        r_id  <= w_arb_idx;
                    end
                end
                LOAD: begin
                    r_eng_a <= a_i[int'(r_id)*n +: n];
                    r_eng_b <= b_i[int'(r_id)*n +: n];
                    r_cnt   <= '0;
                    r_stab  <= '0;
                end
                RUN: begin
                    if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
                    if (w_settled && eng_fl_i) r_stab <= r_stab + STB_W'(1);
                    else                       r_stab <= '0;
                    // Engine is still out of reset here, so its outputs are captured
                    // on the way into DONE and presented alongside done_o.
                    if (w_finish) begin
                        r_done <= N_REQ'(1) << r_id;
                        r_yint <= w_tmo ? '0 : eng_yint_i;
                        r_ydec <= w_tmo ? '0 : eng_ydec_i;
                    end
                end
                DONE: begin
                    r_ptr <= IW'(rr_wrap(int'(r_id) + 1, N_REQ));
                end
                default: ;
            endcase
        end
    end

`ifdef MAG_SCHED_TIMEOUT_EN
    logic r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (r_state == RUN) && w_tmo;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign gnt_o     = r_gnt;
    assign done_o    = r_done;
    assign yint_o    = r_yint;
    assign ydec_o    = r_ydec;
    assign id_o      = r_id;
    assign busy_o    = (r_state != IDLE);
    assign eng_a_o   = r_eng_a;
    assign eng_b_o   = r_eng_b;
    assign eng_rst_o = (r_state != RUN);

endmodule

// File: tb/tb_mag_sched.sv
// Bench for mag_sched: behavioural engine, transaction-timeline model checked every cycle,
// plus directed vectors with literal expectations.
module tb_mag_sched;

    localparam int N      = 4;
    localparam int W      = 16;
    localparam int SETTLE = 4;
    localparam int STABLE = 2;
    localparam int TMO    = 1023;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*W-1:0]  a;
    logic [N*W-1:0]  b;
    logic [N-1:0]    gnt_o;
    logic [N-1:0]    done_o;
    logic [2*W:0]    yint_o;
    logic [W-1:0]    ydec_o;
    logic [1:0]      id_o;
    logic            busy_o;
    logic            err_o;
    logic [W-1:0]    eng_a_o;
    logic [W-1:0]    eng_b_o;
    logic            eng_rst_o;
    logic            eng_fl;
    logic [2*W:0]    eng_y;
    logic [W-1:0]    eng_d;

    int n_chk = 0;
    int n_err = 0;
    int eng_lat = 3;
    bit eng_hang = 0;

    mag_sched #(
        .N_REQ   (N),
        .n       (W),
        .SETTLE  (SETTLE),
        .STABLE  (STABLE),
        .TMO_CYC (TMO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .a_i        (a),
        .b_i        (b),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .yint_o     (yint_o),
        .ydec_o     (ydec_o),
        .id_o       (id_o),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .eng_a_o    (eng_a_o),
        .eng_b_o    (eng_b_o),
        .eng_rst_o  (eng_rst_o),
        .eng_fl_i   (eng_fl),
        .eng_yint_i (eng_y),
        .eng_ydec_i (eng_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Fixed-point magnitude: y * 2^W = floor(sqrt((x^2+y^2) * 2^(2W))).
    task automatic mag(input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [2*W:0] yi, output logic [W-1:0] yd);
        logic [127:0] v, r, t;
        v = (128'(x) * 128'(x) + 128'(y) * 128'(y)) << (2 * W);
        r = '0;
        for (int i = 40; i >= 0; i--) begin
            t = r | (128'd1 << i);
            if (t * t <= v) r = t;
        end
        yi = r[3*W:W];
        yd = r[W-1:0];
    endtask

    // Engine stand-in: converges eng_lat cycles after its reset is released.
    initial begin
        int ecnt;
        logic [2*W:0] ty;
        logic [W-1:0] td;
        ecnt = 0; eng_fl = 1'b0; eng_y = '0; eng_d = '0;
        forever begin
            @(negedge clk);
            if (eng_rst_o) begin
                ecnt = 0; eng_fl = 1'b0; eng_y = '0; eng_d = '0;
            end else begin
                ecnt++;
                eng_fl = !eng_hang && (ecnt >= eng_lat);
                mag(eng_a_o, eng_b_o, ty, td);
                eng_y = ty;
                eng_d = td;
            end
        end
    end

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    // Transaction timeline model: t=0 grant cycle, t=1..jend engine running, t=jend+1 done.
    bit           m_idle = 1;
    int           m_ptr = 0, m_id = 0, m_t = 0, m_jend = 0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [2*W:0] m_res_y = '0, m_y = '0;
    logic [W-1:0] m_res_d = '0, m_d = '0;
    bit           m_res_err = 0;

    always @(negedge clk) begin
        logic [N-1:0] e_gnt, e_done;
        logic         e_rst, e_err;
        int           conv;
        if (rst) begin
            m_idle = 1; m_ptr = 0; m_id = 0; m_t = 0; m_y = '0; m_d = '0;
        end
        e_gnt = '0; e_done = '0; e_rst = 1'b1; e_err = 1'b0;
        if (!m_idle) begin
            if (m_t == 0) e_gnt = N'(1) << m_id;
            else if (m_t <= m_jend) e_rst = 1'b0;
            else begin
                e_done = N'(1) << m_id;
                m_y = m_res_y; m_d = m_res_d; e_err = m_res_err;
            end
        end
        chk("m_gnt", gnt_o, e_gnt);
        chk("m_done", done_o, e_done);
        chk("m_busy", busy_o, !m_idle);
        chk("m_eng_rst", eng_rst_o, e_rst);
        chk("m_id", id_o, m_id);
        chk("m_err", err_o, e_err);
        chk("m_yint", yint_o, m_y);
        chk("m_ydec", ydec_o, m_d);
        if (!e_rst) begin
            chk("m_eng_a", eng_a_o, m_a);
            chk("m_eng_b", eng_b_o, m_b);
        end
        if (!rst) begin
            if (m_idle) begin
                if (req != '0) begin
                    m_id = pick(req, m_ptr); m_idle = 0; m_t = 0;
                end
            end else if (m_t == 0) begin
                m_a = a[m_id*W +: W];
                m_b = b[m_id*W +: W];
                mag(m_a, m_b, m_res_y, m_res_d);
                m_res_err = 0;
                conv = ((eng_lat > SETTLE + 1) ? eng_lat : SETTLE + 1) + STABLE - 1;
                if (eng_hang) begin
`ifdef MAG_SCHED_TIMEOUT_EN
                    m_jend = TMO; m_res_y = '0; m_res_d = '0; m_res_err = 1;
`else
                    m_jend = 32'h7fff_ffff;
`endif
                end else begin
                    m_jend = conv;
                end
                m_t = 1;
            end else if (m_t <= m_jend) begin
                m_t++;
            end else begin
                m_idle = 1;
                m_ptr = (m_id + 1) % N;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int maxc, output int cyc);
        cyc = -1;
        for (int k = 1; k <= maxc; k++) begin
            tick();
            if (gnt_o != '0) begin cyc = k; break; end
        end
        if (cyc < 0) chk("gnt_timeout", 0, 1);
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        cyc = -1;
        for (int k = 1; k <= maxc; k++) begin
            tick();
            if (done_o != '0) begin cyc = k; break; end
        end
        if (cyc < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int maxc);
        bit ok;
        ok = 0;
        for (int k = 0; k < maxc; k++) begin
            if (!busy_o) begin ok = 1; break; end
            tick();
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        int cyc;
        int order [5];
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        rst = 1'b1; req = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_eng_rst", eng_rst_o, 1);
        chk("rst_id", id_o, 0);
        chk("rst_eng_a", eng_a_o, 0);
        chk("rst_yint", yint_o, 0);
        rst = 1'b0;
        tick();

        // 3,4 -> 5 on requester 0, request dropped right after the grant.
        a[0*W +: W] = 16'd3; b[0*W +: W] = 16'd4; req = 4'b0001;
        tick();
        chk("t1_gnt", gnt_o, 4'b0001);
        req = '0;
        wait_done(50, cyc);
        chk("t1_latency", cyc, 7);
        chk("t1_done", done_o, 4'b0001);
        chk("t1_yint", yint_o, 5);
        chk("t1_ydec", ydec_o, 0);
        wait_idle(10);

        // Zero operands on requester 1.
        a[1*W +: W] = 16'd0; b[1*W +: W] = 16'd0; req = 4'b0010;
        wait_gnt(10, cyc);
        req = '0;
        wait_done(50, cyc);
        chk("t2_done", done_o, 4'b0010);
        chk("t2_yint", yint_o, 0);
        chk("t2_ydec", ydec_o, 0);
        wait_idle(10);

        // Requester 2 drops req and scrambles its operands after the grant cycle.
        a[2*W +: W] = 16'd5; b[2*W +: W] = 16'd12; req = 4'b0100;
        wait_gnt(10, cyc);
        chk("t3_gnt", gnt_o, 4'b0100);
        req = '0;
        tick();
        a[2*W +: W] = 16'h1234; b[2*W +: W] = 16'h4321;
        wait_done(50, cyc);
        chk("t3_done", done_o, 4'b0100);
        chk("t3_yint", yint_o, 13);
        chk("t3_ydec", ydec_o, 0);
        wait_idle(10);

        // Full-scale operands, engine converging after the settle window.
        eng_lat = 10;
        a[3*W +: W] = 16'hFFFF; b[3*W +: W] = 16'hFFFF; req = 4'b1000;
        wait_gnt(10, cyc);
        req = '0;
        wait_done(50, cyc);
        chk("t4_latency", cyc, 12);
        chk("t4_done", done_o, 4'b1000);
        chk("t4_yint", yint_o, 92680);
        wait_idle(10);
        eng_lat = 3;

        // All four requesting continuously.
        for (int k = 0; k < N; k++) begin
            a[k*W +: W] = W'(k + 1);
            b[k*W +: W] = W'(3 * (k + 1));
        end
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(50, cyc);
            order[g] = oh2i(gnt_o);
            if (g == 4) req = '0;
        end
        for (int g = 0; g < 5; g++) chk("t5_order", order[g], exp_order[g]);
        wait_done(50, cyc);
        wait_idle(10);

        // Reset while the engine never converges.
        eng_hang = 1;
        req = 4'b0100;
        wait_gnt(10, cyc);
        req = '0;
        repeat (20) tick();
        chk("t6_busy_before", busy_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_busy", busy_o, 0);
        chk("t6_eng_rst", eng_rst_o, 1);
        chk("t6_id", id_o, 0);
        chk("t6_yint", yint_o, 0);
        repeat (2) tick();
        rst = 1'b0;
        eng_hang = 0;
        tick();
        req = 4'b1111;
        tick();
        chk("t6_restart_gnt", gnt_o, 4'b0001);
        req = '0;
        wait_done(50, cyc);
        wait_idle(10);

`ifdef MAG_SCHED_TIMEOUT_EN
        eng_hang = 1;
        req = 4'b0010;
        wait_gnt(10, cyc);
        req = '0;
        wait_done(TMO + 50, cyc);
        chk("t7_latency", cyc, TMO + 1);
        chk("t7_done", done_o, 4'b0010);
        chk("t7_err", err_o, 1);
        chk("t7_yint", yint_o, 0);
        eng_hang = 0;
        wait_idle(10);
`endif

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
